// File: rtl/mem_responder.sv
// CPU memory-bus target: word RAM plus an MMIO window (console FIFO, status, cycle counter).
// Optional build macro ROM_PROTECT_EN makes RAM words below ROM_WORDS read-only.
module mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] OUT_ADDR    = 32'hFFFF_FF00,
  parameter logic [31:0] STATUS_ADDR = 32'hFFFF_FF01,
  parameter logic [31:0] CYCLE_ADDR  = 32'hFFFF_FF02,
  parameter int          ROM_WORDS   = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] datao,
  input  logic        rw,
  output logic [31:0] data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              PW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = PW + 1;
  localparam logic [31:0]     DEPTH_W    = 32'(DEPTH);
  localparam logic [31:0]     ROM_W      = 32'(ROM_WORDS);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

`ifdef ROM_PROTECT_EN
  localparam bit ROM_PROTECT = 1'b1;
`else
  localparam bit ROM_PROTECT = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic is_write;
  logic in_ram;
  logic hit_out;
  logic hit_status;
  logic hit_cycle;
  logic rom_hit;
  logic ram_we;

  assign is_write   = ~rw;
  assign in_ram     = (address < DEPTH_W);
  assign hit_out    = (address == OUT_ADDR);
  assign hit_status = (address == STATUS_ADDR);
  assign hit_cycle  = (address == CYCLE_ADDR);
  assign rom_hit    = ROM_PROTECT && (address < ROM_W);
  assign ram_we     = is_write & in_ram & ~rom_hit & ~reset;

  // ---------------------------------------------------------------------------
  // Storage: RAM and FIFO entries are never reset
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q      [DEPTH];
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [CW-1:0] count_q,     count_d;
  logic          overflow_q,  overflow_d;
  logic          push_seen_q, push_seen_d;
  logic [31:0]   cycle_q,     cycle_d;

  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic do_pop;
  logic do_push;
  logic drop_push;
  logic ovf_clear;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);

  // Console handshake: out_data/out_valid present the FIFO head; the head is
  // consumed on any posedge where out_valid & out_ready are both high.
  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];
  assign overflow   = overflow_q;

  // A held console write pushes only on the first cycle of the run.
  assign push_req   = is_write & hit_out & ~push_seen_q;
  assign do_pop     = out_valid & out_ready;
  assign do_push    = push_req & (~fifo_full | do_pop);
  assign drop_push  = push_req & fifo_full & ~do_pop;
  assign ovf_clear  = is_write & hit_status & datao[2];

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    push_seen_d = is_write & hit_out;
    cycle_d     = cycle_q + 32'd1;

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end

    // Clear first so that a coincident set takes priority.
    if (ovf_clear) begin
      overflow_d = 1'b0;
    end
    if (drop_push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      push_seen_q <= 1'b0;
      cycle_q     <= 32'd0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      push_seen_q <= push_seen_d;
      cycle_q     <= cycle_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem_q[address[AW-1:0]] <= datao;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) begin
      fifo_mem_q[wr_ptr_q] <= datao[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: combinational, old RAM contents on read-during-write
  // ---------------------------------------------------------------------------
  logic [7:0]  count8;
  logic [31:0] status_word;

  assign count8      = 8'(count_q);
  assign status_word = {16'b0, count8, 5'b0, overflow_q, fifo_full, fifo_empty};

  always_comb begin
    data = 32'd0;
    if (rw) begin
      if (in_ram) begin
        data = mem_q[address[AW-1:0]];
      end else if (hit_status) begin
        data = status_word;
      end else if (hit_cycle) begin
        data = cycle_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed test-plan sequences plus random traffic
// checked against a queue-based behavioural model.
module tb_mem_responder;

  localparam int          DEPTH       = 1024;
  localparam int          FIFO_DEPTH  = 16;
  localparam logic [31:0] OUT_ADDR    = 32'hFFFF_FF00;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FF01;
  localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_FF02;
  localparam int          ROM_WORDS   = 256;

`ifdef ROM_PROTECT_EN
  localparam bit ROM_ON = 1'b1;
`else
  localparam bit ROM_ON = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rw = 1'b1;
  logic        out_ready = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] datao = 32'd0;
  logic [31:0] data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        overflow;

  always #5 clock = ~clock;

  mem_responder #(
    .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .OUT_ADDR(OUT_ADDR),
    .STATUS_ADDR(STATUS_ADDR), .CYCLE_ADDR(CYCLE_ADDR), .ROM_WORDS(ROM_WORDS)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .datao(datao), .rw(rw),
    .data(data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard queues and counters
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]  mode;   // 0 exact, 1 must differ, 2 unknown contents
    logic [31:0] val;
  } rd_exp_t;

  typedef struct packed {
    logic valid;
    logic ovf;
  } cyc_exp_t;

  rd_exp_t    rd_q[$];
  cyc_exp_t   cyc_q[$];
  logic [7:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem[int];
  logic [7:0]  m_fifo[$];
  logic        m_ovf = 1'b0;
  logic        m_prev_out = 1'b0;
  logic [31:0] m_cyc = 32'd0;

  task automatic step(input logic rst, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    rd_exp_t  e;
    cyc_exp_t c;
    bit out_wr, pop, full, push;
    @(posedge clock);
    #1;
    reset = rst; rw = r; address = a; datao = d; out_ready = rdy;

    c.valid = (m_fifo.size() != 0);
    c.ovf   = m_ovf;
    cyc_q.push_back(c);

    if (r && !rst) begin
      e.mode = 2'd0;
      e.val  = 32'd0;
      if (a < DEPTH) begin
        if (m_mem.exists(int'(a))) e.val = m_mem[int'(a)];
        else e.mode = 2'd2;
      end else if (a == STATUS_ADDR) begin
        e.val = {16'b0, 8'(m_fifo.size()), 5'b0, m_ovf,
                 1'(m_fifo.size() == FIFO_DEPTH), 1'(m_fifo.size() == 0)};
      end else if (a == CYCLE_ADDR) begin
        e.val = m_cyc;
      end
      rd_q.push_back(e);
    end

    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_prev_out = 1'b0;
      m_cyc = 32'd0;
    end else begin
      out_wr = !r && (a == OUT_ADDR);
      pop    = (m_fifo.size() != 0) && rdy;
      full   = (m_fifo.size() == FIFO_DEPTH);
      push   = out_wr && !m_prev_out;
      if (pop) void'(m_fifo.pop_front());
      if (!r && a == STATUS_ADDR && d[2]) m_ovf = 1'b0;
      if (push) begin
        if (!full || pop) begin
          m_fifo.push_back(d[7:0]);
          exp_q.push_back(d[7:0]);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (!r && a < DEPTH && !(ROM_ON && a < ROM_WORDS)) m_mem[int'(a)] = d;
      m_prev_out = out_wr;
      m_cyc = m_cyc + 32'd1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
    step(1'b0, 1'b0, a, d, rdy);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy);
    step(1'b0, 1'b1, a, 32'd0, rdy);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 32'd0, 32'd0, 1'b0);
  endtask

  // Turns the most recent read expectation into "must not equal v".
  task automatic expect_differ(input logic [31:0] v);
    rd_exp_t e;
    e = rd_q.pop_back();
    e.mode = 2'd1;
    e.val = v;
    rd_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops expectations whenever the DUT presents a response
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    cyc_exp_t c;
    rd_exp_t  e;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      check("out_valid", 32'(out_valid), 32'(c.valid));
      check("overflow", 32'(overflow), 32'(c.ovf));
      if (!c.valid) check("out_data_empty", 32'(out_data), 32'd0);
    end
    if (reset === 1'b0 && rw === 1'b1 && rd_q.size() > 0) begin
      e = rd_q.pop_front();
      if (e.mode == 2'd0) begin
        check("read_data", data, e.val);
      end else if (e.mode == 2'd1) begin
        checks++;
        if (data === e.val) begin
          failures++;
          $display("FAIL rom_protect actual=%h required_not=%h", data, e.val);
        end
      end
    end
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL drain_unexpected actual=%h expected=none", out_data);
      end else begin
        check("drain_byte", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    logic        rdy;
    int          op;

    rst_cycles(2);
    rd(STATUS_ADDR, 1'b0);

    // RAM write/read and out-of-range read
    wr(32'd5, 32'hDEAD_BEEF, 1'b0);
    rd(32'd5, 1'b0);
    if (ROM_ON) expect_differ(32'hDEAD_BEEF);
    wr(32'(ROM_WORDS + 5), 32'hDEAD_BEEF, 1'b0);
    rd(32'(ROM_WORDS + 5), 1'b0);
    rd(32'(DEPTH + 3), 1'b0);

    // Held console write pushes once
    for (int i = 0; i < 3; i++) wr(OUT_ADDR, 32'h41, 1'b0);
    rd(STATUS_ADDR, 1'b0);
    rd(OUT_ADDR, 1'b1);
    rd(STATUS_ADDR, 1'b0);

    // Overflow on the 17th push, drain, clear
    for (int i = 0; i < 17; i++) begin
      wr(OUT_ADDR, 32'(8'h60 + i), 1'b0);
      rd(OUT_ADDR, 1'b0);
    end
    rd(STATUS_ADDR, 1'b0);
    for (int i = 0; i < 16; i++) rd(OUT_ADDR, 1'b1);
    rd(STATUS_ADDR, 1'b0);
    wr(STATUS_ADDR, 32'd4, 1'b0);
    rd(STATUS_ADDR, 1'b0);

    // Push and pop together while full
    for (int i = 0; i < 16; i++) begin
      wr(OUT_ADDR, 32'(8'h80 + i), 1'b0);
      rd(OUT_ADDR, 1'b0);
    end
    wr(OUT_ADDR, 32'hAA, 1'b1);
    rd(STATUS_ADDR, 1'b0);
    for (int i = 0; i < 16; i++) rd(OUT_ADDR, 1'b1);

    // Cycle counter after reset, then reset mid-stream
    rst_cycles(1);
    for (int i = 0; i < 10; i++) rd(OUT_ADDR, 1'b0);
    rd(CYCLE_ADDR, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wr(OUT_ADDR, 32'(8'hC0 + i), 1'b0);
      rd(OUT_ADDR, 1'b0);
    end
    rst_cycles(1);
    rd(CYCLE_ADDR, 1'b0);
    rd(32'(ROM_WORDS + 5), 1'b0);
    rd(STATUS_ADDR, 1'b0);

    // ROM protection boundary
    wr(32'd3, 32'h1234_5678, 1'b0);
    rd(32'd3, 1'b0);
    if (ROM_ON) expect_differ(32'h1234_5678);
    wr(32'(ROM_WORDS), 32'h1234_5678, 1'b0);
    rd(32'(ROM_WORDS), 1'b0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      op  = int'($urandom_range(0, 10));
      rdy = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31))
                                        : 32'(ROM_WORDS - 4 + int'($urandom_range(0, 8)));
      if ($urandom_range(0, 149) == 0) begin
        rst_cycles(1);
      end else begin
        case (op)
          0, 1:    wr(a, $urandom, rdy);
          2, 3:    rd(a, rdy);
          4, 5, 6: wr(OUT_ADDR, $urandom, rdy);
          7:       rd(STATUS_ADDR, rdy);
          8:       wr(STATUS_ADDR, $urandom, rdy);
          9:       rd(CYCLE_ADDR, rdy);
          default: rd(32'(DEPTH) + 32'($urandom_range(0, 100)), rdy);
        endcase
      end
    end

    for (int i = 0; i < 20; i++) rd(OUT_ADDR, 1'b1);
    @(negedge clock);
    #1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("reads_left", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
